ecg_bit_packer: RTL

Downstream stage of the BP-mode entropy encoder: consumes the registered per-group output (encoded ECG field plus deferred sign bits) and packs the variable-length fields MSB-first into fixed-width bitstream words for the rate buffer. A left-justified accumulator absorbs the 0–54 bits produced per group and emits OUT_W-bit words under a valid/ready handshake, with back-pressure and an explicit end-of-slice flush.

---
 rtl/ecg_pkg.sv | 22 ++
 rtl/ecg_field_merge.sv | 29 ++
 rtl/ecg_bit_packer.sv | 110 +++++++++++
 3 files changed

// File: rtl/ecg_pkg.sv
// Shared constants, FSM state type and size-legality check for the ECG bit packer.
package ecg_pkg;

  localparam int ECG_FIELD_W = 50;
  localparam int ECG_SIZE_W  = 7;
  localparam int SIGN_W      = 4;
  localparam int SIGN_SIZE_W = 3;
  localparam int FIELD_W     = ECG_FIELD_W + SIGN_W;
  localparam int FIELD_LEN_W = 6;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_FLUSH = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  function automatic logic sizes_legal(input logic [ECG_SIZE_W-1:0]  n_ecg,
                                       input logic [SIGN_SIZE_W-1:0] n_sign);
    return (n_ecg <= 7'(ECG_FIELD_W)) && (n_sign <= 3'(SIGN_W));
  endfunction

endpackage

// File: rtl/ecg_field_merge.sv
// Joins the right-justified ECG field and deferred sign bits into one
// left-justified 54-bit field with its bit length. Result is meaningful only for legal sizes.
module ecg_field_merge
  import ecg_pkg::*;
(
  input  logic [ECG_FIELD_W-1:0] encoded_ecg,
  input  logic [ECG_SIZE_W-1:0]  n_ecg,
  input  logic [SIGN_W-1:0]      sign_bits,
  input  logic [SIGN_SIZE_W-1:0] n_sign,
  output logic [FIELD_W-1:0]     field,
  output logic [FIELD_LEN_W-1:0] field_len
);

  localparam logic [FIELD_LEN_W-1:0] FIELD_W6 = FIELD_LEN_W'(FIELD_W);

  logic [63:0]          ecg_mask;
  logic [SIGN_W-1:0]    sign_mask;
  logic [FIELD_W-1:0]   right_just;

  always_comb begin
    ecg_mask   = (64'd1 << n_ecg) - 64'd1;
    sign_mask  = SIGN_W'((5'd1 << n_sign) - 5'd1);
    right_just = FIELD_W'((({14'd0, encoded_ecg} & ecg_mask) << n_sign)
                          | {60'd0, sign_bits & sign_mask});
    field_len  = FIELD_LEN_W'(n_ecg) + FIELD_LEN_W'(n_sign);
    field      = right_just << (FIELD_W6 - field_len);
  end

endmodule

// File: rtl/ecg_bit_packer.sv
// Packs variable-length ECG group fields MSB-first into OUT_W-bit words
// through a left-justified accumulator, with back-pressure and slice flush.
//
// state | meaning
// RUN   | accepting beats, emitting full words
// FLUSH | input closed, padded tail draining
// DONE  | one-cycle flush_done pulse, then back to RUN
module ecg_bit_packer
  import ecg_pkg::*;
#(
  parameter int OUT_W = 32,
  parameter int ACC_W = 128
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   valid_op,
  input  logic [ECG_FIELD_W-1:0] encoded_ECG,
  input  logic [ECG_SIZE_W-1:0]  sizeof_encoded_ECG,
  input  logic [SIGN_W-1:0]      sign_bits,
  input  logic [SIGN_SIZE_W-1:0] sizeof_sign_bits,
  input  logic                   flush,
  output logic [OUT_W-1:0]       out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   flush_done,
  output logic                   err_size,
  output logic [15:0]            words_out
);

  localparam logic [7:0] OUT_W8   = 8'(OUT_W);
  localparam logic [7:0] FILL_MAX = 8'(ACC_W - FIELD_W - OUT_W);

  state_t                 state, state_n;
  logic [ACC_W-1:0]       acc, acc_n;
  logic [7:0]             fill, fill_n;
  logic                   rdy_en;
  logic                   pop, accept, legal, beat_ok, beat_bad;
  logic [FIELD_W-1:0]     field;
  logic [FIELD_LEN_W-1:0] field_len;
  logic [ACC_W-1:0]       ins_word;

  ecg_field_merge u_merge (
    .encoded_ecg (encoded_ECG),
    .n_ecg       (sizeof_encoded_ECG),
    .sign_bits   (sign_bits),
    .n_sign      (sizeof_sign_bits),
    .field       (field),
    .field_len   (field_len)
  );

  // Outputs depend only on registered state; bits below fill are always zero.
  assign out_valid  = (fill >= OUT_W8);
  assign out_data   = acc[ACC_W-1 -: OUT_W];
  assign flush_done = (state == ST_DONE);
  assign in_ready   = rdy_en && (state == ST_RUN) && (fill <= FILL_MAX);

  assign pop      = out_valid && out_ready;
  assign accept   = in_valid && in_ready;
  assign legal    = sizes_legal(sizeof_encoded_ECG, sizeof_sign_bits);
  assign beat_ok  = accept && valid_op && legal;
  assign beat_bad = accept && valid_op && !legal;
  assign ins_word = {field, {(ACC_W-FIELD_W){1'b0}}};

  always_comb begin
    acc_n   = acc;
    fill_n  = fill;
    state_n = state;
    if (pop) begin
      acc_n  = acc << OUT_W;
      fill_n = fill - OUT_W8;
    end
    if (beat_ok) begin
      acc_n  = acc_n | (ins_word >> fill_n);
      fill_n = fill_n + {2'b00, field_len};
    end
    case (state)
      ST_RUN: begin
        // Round up to a word boundary; the padding is the zeros already below fill.
        if (flush) begin
          fill_n  = (fill_n + OUT_W8 - 8'd1) & ~(OUT_W8 - 8'd1);
          state_n = ST_FLUSH;
        end
      end
      ST_FLUSH: if (fill == 8'd0) state_n = ST_DONE;
      ST_DONE:  state_n = ST_RUN;
      default:  state_n = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_RUN;
      acc       <= '0;
      fill      <= '0;
      rdy_en    <= 1'b0;
      err_size  <= 1'b0;
      words_out <= '0;
    end else begin
      state  <= state_n;
      acc    <= acc_n;
      fill   <= fill_n;
      rdy_en <= 1'b1;
      if (beat_bad) err_size <= 1'b1;
      if (pop) words_out <= words_out + 16'd1;
    end
  end

endmodule
